uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receive controller. Detects the start-bit falling edge on the asynchronous serial line, then times and samples each bit at mid-bit.
- Shifts data LSB-first and checks the stop bit. Delivers each byte with a one-cycle valid pulse.
- Sits between the external rx pin and the UART receive FIFO/register bank. Sequences the edge-detect, bit-counter and shift-register datapath.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; even, ≥4.
- DATA_BITS, 8, data bits per frame; 5..9.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  high allows new frame detection.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last received word.
- rx_valid  output  1  one-cycle pulse: rx_data updated, frame good.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; counters=0; rx_data=0; rx_valid=0; frame_err=0; busy=0.
  - Sync flops and edge-history flop preset to 1, so no false edge after reset.
  - Reset mid-frame aborts the frame with no pulse.
- Input sync: rx passes 2 flops (rx_s). A third flop holds the previous rx_s value. fall = prev & ~rx_s.
- Counters:
  - bit_cnt: $clog2(CLKS_PER_BIT) bits, counts clock cycles within a bit period.
  - idx_cnt: $clog2(DATA_BITS+1) bits, counts bits received.
  - HALF = CLKS_PER_BIT/2.
- Cycle E = first cycle fall==1 while state==IDLE and enable==1.
- FSM transitions:
  - IDLE: on fall&enable, go to START, bit_cnt=0. Otherwise stay.
  - START: bit_cnt increments each cycle. At bit_cnt==HALF-1 (cycle E+HALF), sample rx_s:
    - rx_s==1: false start, return to IDLE, no pulse.
    - rx_s==0: go to DATA, bit_cnt=0, idx_cnt=0.
  - DATA: at bit_cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift, LSB-first line order), idx_cnt+1, bit_cnt=0. After DATA_BITS samples, go to STOP (or PARITY if enabled).
  - STOP: at bit_cnt==CLKS_PER_BIT-1, sample rx_s and return to IDLE:
    - rx_s==1: rx_data <= shift register; rx_valid=1 for one cycle.
    - rx_s==0: frame_err=1 for one cycle; rx_data unchanged.
- Sample timing: data bit i is sampled at cycle E+HALF+(i+1)*CLKS_PER_BIT. Stop bit is sampled at E+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
- Pulse timing: pulses are registered and high in the cycle after the stop sample.
- enable:
  - Only gates IDLE→START.
  - Deassertion mid-frame does not abort; the frame completes.
- Line held low after a frame: no new start until rx_s returns high and falls again (edge, not level).
- Back-to-back frames: falling edge seen in the IDLE cycle following the stop sample is accepted.
- rx_valid and frame_err are never high together.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP and samples one bit period.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Added output parity_err, 1 bit, reset 0. Pulses in the same cycle as rx_valid would.
  - On parity_err, rx_valid is suppressed and rx_data is not updated. Parity error takes precedence over a good stop bit.
  - frame_err still reported on a bad stop bit (both errors may pulse together).
  - Stop sample shifts by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Default constants CLKS_PER_BIT_DEF=16, DATA_BITS_DEF=8.
- Sub-module uart_rx_sync:
  - 2-flop synchronizer plus falling-edge detector; outputs rx_s and fall.
  - Sync reset presets its flops to 1.
  - Instantiated once.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8, parity off unless stated):
- Frame 0xA5 with stop=1, enable=1 → rx_valid at E+153 only; rx_data=0xA5; frame_err=0; busy high E+1..E+152.
- Start-bit glitch (rx low 4 cycles) → no pulses; busy falls at E+9; rx_data unchanged.
- Frame 0x3C with stop=0 → frame_err pulse at E+153; rx_valid=0; rx_data keeps previous 0xA5.
- Back-to-back frames 0x01,0xFF with no idle gap → two rx_valid pulses exactly 160 cycles apart; data 0x01 then 0xFF.
- enable=0 at frame start → ignored. enable dropped mid-frame → 0x5A still delivered.
- reset=0 asserted at E+80 → all outputs 0 next cycle; no pulse. UART_RX_PARITY_EN with 0x07 and parity=0 → parity_err at E+169, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive controller
//
// Purpose: receiver FSM state encoding and default frame geometry.
// Ports:   none (package).
// Config:  UART_RX_PARITY_EN enables the PARITY state in the controller.

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx pin synchronizer and falling-edge detector
//
// Purpose: brings the asynchronous rx line into the clk domain through two
//          flops and flags a high-to-low transition of the synchronized line.
// Ports:
//   clk   in   system clock, rising edge
//   reset in   synchronous active-low reset; presets all flops to idle-high
//   rx    in   asynchronous serial line
//   rx_s  out  synchronized line
//   fall  out  high for one cycle when rx_s goes 1 -> 0

module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // Presetting to 1 matches the idle line, so leaving reset never
   // manufactures a falling edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= rx;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rx_s = sync;
   assign fall = prev & ~sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller, LSB-first, mid-bit sampling
//
// Purpose: detects a start edge, validates the start bit at half a bit
//          period, samples DATA_BITS data bits (and optional even parity)
//          one bit period apart, checks the stop bit and pulses the result.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   enable     in   allows detection of a new frame (IDLE -> START only)
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  last good received word
//   rx_valid   out  one-cycle pulse: rx_data updated, frame good
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   busy       out  high whenever the FSM is not IDLE
//   parity_err out  one-cycle pulse: even parity failed (UART_RX_PARITY_EN only)
// Config: define UART_RX_PARITY_EN to add the PARITY state and parity_err.

module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int BW   = $clog2(CLKS_PER_BIT);
   localparam int IW   = $clog2(DATA_BITS + 1);
   localparam int HALF = CLKS_PER_BIT / 2;

   localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   rx_state_t            state;
   logic [BW-1:0]        bit_cnt;
   logic [IW-1:0]        idx_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_s;
   logic                 fall;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .rx_s  (rx_s),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         idx_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
         par_bad    <= 1'b0;
`endif
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (fall && enable) begin
                  state <= START;
               end
            end

            // Half a bit period after the edge we are mid-start-bit; a high
            // line there means the edge was a glitch.
            START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  idx_cnt <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end

            // Line order is LSB first, so each new bit enters at the MSB and
            // the word is aligned once all DATA_BITS have been shifted in.
            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  idx_cnt <= idx_cnt + 1'b1;
                  if (idx_cnt == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  par_bad <= (^shreg) ^ rx_s;
                  state   <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
`ifdef UART_RX_PARITY_EN
                  // Parity failure blocks delivery even with a good stop bit;
                  // a bad stop bit is still reported alongside it.
                  frame_err  <= ~rx_s;
                  parity_err <= par_bad;
                  if (rx_s && !par_bad) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end
`else
                  if (rx_s) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
`endif
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end

            default: begin
               state   <= IDLE;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl

module tb_uart_rx_ctrl;

   localparam int CPB  = 16;
   localparam int DB   = 8;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS     = DB + 2 + PB;
   localparam int PULSE_OFF = HALF + (DB + 1 + PB) * CPB + 1;

   typedef struct {
      int         cyc;
      logic [2:0] code;   // {parity_err, frame_err, rx_valid}
      logic [7:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          rx;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          busy;
   logic          pe;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err(pe)
`endif
   );

`ifndef UART_RX_PARITY_EN
   assign pe = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [2:0] code, input logic [7:0] d);
      exp_t e;
      e.cyc  = c;
      e.code = code;
      e.data = d;
      sb.push_back(e);
   endtask

   // One frame on the line, each bit held CPB cycles; the line is left at
   // the stop-bit level afterwards.
   task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_flip);
      rx = 1'b0;
      step(CPB);
      for (int i = 0; i < DB; i++) begin
         rx = d[i];
         step(CPB);
      end
      if (PB == 1) begin
         rx = (^d) ^ par_flip;
         step(CPB);
      end
      rx = stop;
      step(CPB);
   endtask

   // Scoreboard: every output pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rx_valid || frame_err || pe) begin
         exp_t e;
         chk("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {29'd0, pe, frame_err, rx_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", {29'd0, pe, frame_err, rx_valid}, {29'd0, e.code});
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_data", {24'd0, rx_data}, {24'd0, e.data});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      reset  = 1'b0;
      enable = 1'b1;
      rx     = 1'b1;
      step(5);
      chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      step(10);

      // Good frame 0xA5 with busy window
      e = cyc + 2;
      push(e + PULSE_OFF, 3'b001, 8'hA5);
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            wait_until(e);                 chk("busy_at_E", {31'd0, busy}, 32'd0);
            wait_until(e + 1);             chk("busy_E1", {31'd0, busy}, 32'd1);
            wait_until(e + PULSE_OFF - 1); chk("busy_last", {31'd0, busy}, 32'd1);
            wait_until(e + PULSE_OFF);     chk("busy_after", {31'd0, busy}, 32'd0);
         end
      join
      step(20);

      // Start-bit glitch
      e = cyc + 2;
      fork
         begin
            rx = 1'b0;
            step(4);
            rx = 1'b1;
         end
         begin
            wait_until(e + HALF);     chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
            wait_until(e + HALF + 1); chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
         end
      join
      step(30);
      chk("glitch_rx_data", {24'd0, rx_data}, 32'h0A5);

      // Bad stop bit, then line held low: no retrigger without an edge
      e = cyc + 2;
      push(e + PULSE_OFF, 3'b010, 8'hA5);
      send_frame(8'h3C, 1'b0, 1'b0);
      step(40);
      chk("held_low_busy", {31'd0, busy}, 32'd0);
      rx = 1'b1;
      step(20);
      chk("after_ferr_data", {24'd0, rx_data}, 32'h0A5);

      // Back-to-back frames
      e = cyc + 2;
      push(e + PULSE_OFF, 3'b001, 8'h01);
      push(e + PULSE_OFF + NBITS * CPB, 3'b001, 8'hFF);
      send_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      step(20);

      // enable low at frame start: ignored
      enable = 1'b0;
      e = cyc + 2;
      fork
         send_frame(8'h77, 1'b1, 1'b0);
         begin
            wait_until(e + HALF); chk("disabled_busy", {31'd0, busy}, 32'd0);
         end
      join
      step(20);
      enable = 1'b1;
      chk("disabled_data", {24'd0, rx_data}, 32'h0FF);

      // enable dropped mid-frame: frame still delivered
      e = cyc + 2;
      push(e + PULSE_OFF, 3'b001, 8'h5A);
      fork
         send_frame(8'h5A, 1'b1, 1'b0);
         begin
            wait_until(e + 80);
            enable = 1'b0;
         end
      join
      step(20);
      enable = 1'b1;

      // reset mid-frame: outputs cleared, no pulse
      e = cyc + 2;
      fork
         send_frame(8'h96, 1'b1, 1'b0);
         begin
            wait_until(e + 80);
            reset = 1'b0;
            wait_until(e + 81);
            chk("midreset_data", {24'd0, rx_data}, 32'd0);
            chk("midreset_busy", {31'd0, busy}, 32'd0);
            chk("midreset_valid", {31'd0, rx_valid}, 32'd0);
            chk("midreset_ferr", {31'd0, frame_err}, 32'd0);
         end
      join
      step(5);
      reset = 1'b1;
      step(20);

`ifdef UART_RX_PARITY_EN
      // Wrong parity on 0x07: parity_err only, rx_data unchanged
      e = cyc + 2;
      push(e + PULSE_OFF, 3'b100, 8'h00);
      send_frame(8'h07, 1'b1, 1'b1);
      step(20);
`endif

      step(30);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
